spi_txn_scheduler: RTL and testbench
====================================

// Module: spi_txn_scheduler
// PURPOSE
//  Shares the single spi_master_slave engine among NREQ on-chip requesters, e.g. the multiplier result path and the UART command path.
//  Round-robin arbitration, one 16-bit full-duplex SPI frame per grant, per-request SCLK rate select.
//  Inter-frame gap between frames; the response is returned to the granted requester.
// PARAMETERS
//  NREQ            2     number of requesters (2..8)
//  DW              16    SPI frame width
//  GAP_CYCLES      4     idle clk cycles after each frame before the next grant (>=1)
//  TIMEOUT_CYCLES  4096  WAIT-state limit, used only with SPI_TIMEOUT_EN
// PORTS
//  clk           in   1           system clock
//  reset         in   1           synchronous, active-high reset
//  req_valid     in   NREQ        request pending, one bit per requester
//  req_ready     out  NREQ        accept strobe (one-hot, 1 cycle)
//  req_data      in   NREQ*DW     flat tx payloads, requester k at [k*DW +: DW]
//  req_freq      in   NREQ*2      flat freq_control codes, requester k at [k*2 +: 2]
//  rsp_valid     out  NREQ        response strobe to the owning requester (one-hot, 1 cycle)
//  rsp_data      out  DW          received MISO frame, valid with rsp_valid
//  rsp_err       out  1           timeout flag, valid with rsp_valid
//  spi_tx_start  out  1           to slave_tx_start (1-cycle pulse)
//  spi_rx_start  out  1           to slave_rx_start (1-cycle pulse)
//  spi_tx_data   out  DW          to input_reg_data
//  spi_freq      out  2           to freq_control
//  spi_rx_data   in   DW          from output_reg_data
//  spi_rx_valid  in   1           from rx_valid
//  spi_tx_done   in   1           from tx_done (status only)
//  busy          out  1           high in any state other than IDLE
//  grant_id      out  $clog2(NREQ) index of the current/last granted requester
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, rr pointer 0, timeout counter 0.
//  FSM states and transitions:
//   IDLE->ARB when |req_valid.
//   ARB (1 cycle): winner = first set req_valid bit at or after the pointer (wrapping).
//    Assert req_ready[winner]; latch req_data/req_freq; grant_id <= winner; go to LAUNCH.
//   LAUNCH (1 cycle): spi_tx_start=spi_rx_start=1; go to WAIT.
//    spi_tx_data/spi_freq are driven from the latches from LAUNCH until leaving WAIT, then hold their values.
//   WAIT: on spi_rx_valid, capture spi_rx_data and go to RESP.
//    spi_tx_done does not end WAIT; it sets sticky internal tx_seen, which is cleared in ARB.
//   RESP (1 cycle): rsp_valid[grant_id]=1, rsp_data=captured frame; pointer <= grant_id+1 (mod NREQ); go to GAP.
//   GAP: count GAP_CYCLES cycles, then go to IDLE.
//  Latency: req_valid high in IDLE cycle t gives req_ready at t+1, start pulses at t+2, rsp_valid 1 cycle after spi_rx_valid.
//  Handshake: a requester holds req_valid and its payload stable until it sees req_ready. Withdrawing before grant is illegal.
//   A requester may re-assert req_valid from the cycle after req_ready.
//  Fairness: with all NREQ requests held, grants rotate 0,1,..,NREQ-1,0.
//  spi_rx_valid and spi_tx_done outside WAIT are ignored.
//  rsp_data/rsp_err hold their values until the next RESP.
//  Reset mid-frame: immediate return to IDLE with all outputs 0. No response is issued for the aborted frame.
// CONFIGURATION
//  SPI_TIMEOUT_EN defined:
//   WAIT counts cycles; after TIMEOUT_CYCLES cycles without spi_rx_valid, go to RESP with rsp_err=1, rsp_data=0.
//   If spi_rx_valid arrives on the same cycle as the limit, rx_valid wins (rsp_err=0).
//  SPI_TIMEOUT_EN undefined: no counter; WAIT is unbounded; rsp_err is tied to 0.
// STRUCTURE
//  Package spi_sched_pkg: state_t enum (IDLE,ARB,LAUNCH,WAIT,RESP,GAP); FREQ_* constants for the 2-bit codes; DW_DEFAULT.
//  Sub-module rr_arbiter #(NREQ): combinational input (req, ptr), output one-hot grant and index.
//   Pointer update stays in the parent.
// TESTING
//  Bench pairs this block with spi_master_slave; an SPI slave model drives MISO on posedge sclk.
//  1 Single request: req0 data=16'hF1F1, freq=2'b11, slave returns 16'h000A.
//    -> req_ready[0] one cycle after req_valid; MOSI carries F1F1 MSB-first; rsp_valid[0] with rsp_data=16'h000A, rsp_err=0.
//  2 Contention: req0 and req1 held from the same cycle, pointer=0.
//    -> grants in order 0,1,0,1 across 4 frames; each response goes only to its owner.
//    -> At least GAP_CYCLES idle cycles between rsp_valid and the next req_ready.
//  3 Freq per request: req0 freq=2'b00, req1 freq=2'b10.
//    -> spi_freq follows each grant; measured sclk period differs per frame; spi_freq stable throughout WAIT.
//  4 Stray strobes: spi_rx_valid pulsed while IDLE, then a normal request.
//    -> no rsp_valid from the stray pulse; the following frame completes normally.
//  5 Reset mid-frame: reset asserted for 1 cycle in WAIT.
//    -> all outputs 0 next cycle, pointer=0, no rsp_valid; the next request is served from requester 0.
//  6 With SPI_TIMEOUT_EN and TIMEOUT_CYCLES=64: slave never asserts rx_valid.
//    -> rsp_valid with rsp_err=1, rsp_data=0 exactly 64 cycles after entering WAIT; the next grant proceeds normally.

Source files
------------

// File: rtl/spi_txn_scheduler_pkg.sv
// Shared types and constants for the SPI transaction scheduler.
//   state_t     : scheduler FSM states
//   FREQ_*      : 2-bit sclk rate-select codes passed through to the SPI engine
//   DW_DEFAULT  : default SPI frame width
//   next_ptr()  : round-robin pointer increment with wrap
package spi_sched_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARB    = 3'd1,
      LAUNCH = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4,
      GAP    = 3'd5
   } state_t;

   // Rate codes are opaque to the scheduler; the engine maps them to a divider.
   localparam logic [1:0] FREQ_CODE_0 = 2'b00;
   localparam logic [1:0] FREQ_CODE_1 = 2'b01;
   localparam logic [1:0] FREQ_CODE_2 = 2'b10;
   localparam logic [1:0] FREQ_CODE_3 = 2'b11;

   localparam int DW_DEFAULT = 16;

   function automatic int next_ptr(input int id, input int n);
      return (id + 1 >= n) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/spi_txn_scheduler_if.sv
// Bus bundle between the requesters, the scheduler and the SPI engine.
//   req_*        : requester request side (flat, requester k at [k*W +: W])
//   rsp_*        : response side, rsp_valid one-hot per requester
//   spi_*        : engine side (start pulses, tx payload, rate, rx frame/strobes)
// modport slave  : the scheduler's view
// modport master : the environment's view (requesters + engine)
interface spi_txn_scheduler_if
   import spi_sched_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int DW   = DW_DEFAULT
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ*2-1:0]  req_freq;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_data;
   logic               rsp_err;
   logic               spi_tx_start;
   logic               spi_rx_start;
   logic [DW-1:0]      spi_tx_data;
   logic [1:0]         spi_freq;
   logic [DW-1:0]      spi_rx_data;
   logic               spi_rx_valid;
   logic               spi_tx_done;

   modport slave (
      input  req_valid, req_data, req_freq, spi_rx_data, spi_rx_valid, spi_tx_done,
      output req_ready, rsp_valid, rsp_data, rsp_err,
             spi_tx_start, spi_rx_start, spi_tx_data, spi_freq
   );

   modport master (
      output req_valid, req_data, req_freq, spi_rx_data, spi_rx_valid, spi_tx_done,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
             spi_tx_start, spi_rx_start, spi_tx_data, spi_freq
   );
endinterface

// File: rtl/spi_txn_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   req : pending request bits
//   ptr : highest-priority index this round
//   gnt : one-hot winner (0 when no request)
//   idx : winner index (0 when no request)
module rr_arbiter
   import spi_sched_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx
);
   int   k;
   logic found;

   // Scan from ptr upward with wrap; first hit wins.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < NREQ; i++) begin
         k = (int'(ptr) + i) % NREQ;
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = IW'(k);
         end
      end
   end
endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI engine among NREQ requesters: round-robin grant, one DW-bit
// full-duplex frame per grant, per-request rate code, fixed idle gap after
// each frame, response routed back to the owner.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : spi_txn_scheduler_if.slave (requester + engine signals)
//   busy       : high whenever the FSM is not IDLE
//   grant_id   : index of the current/last granted requester
// Build option: define SPI_TIMEOUT_EN to bound WAIT at TIMEOUT_CYCLES and
// report rsp_err=1 / rsp_data=0 on expiry; otherwise WAIT is unbounded and
// rsp_err is constant 0.
module spi_txn_scheduler
   import spi_sched_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int DW             = DW_DEFAULT,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    clk,
   input  logic                    reset,
   spi_txn_scheduler_if.slave      bus,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id
);
   localparam int IW = $clog2(NREQ);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   if (NREQ < 2 || NREQ > 8 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("spi_txn_scheduler: illegal parameter set");
   end

   state_t          state, state_nx;
   logic [IW-1:0]   ptr;
   logic [NREQ-1:0] win_oh;
   logic [IW-1:0]   win_idx;
   logic [GW-1:0]   gap_cnt;
   logic [DW-1:0]   tx_data_q;
   logic [1:0]      freq_q;
   logic [DW-1:0]   rx_data_q;
   logic            tx_seen;
   logic            tmo_hit;
   logic [NREQ-1:0] ready_c, rsp_c;
   logic            start_c;

`ifdef SPI_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
   logic          rsp_err_q;
   // rx_valid on the limit cycle takes precedence over the timeout.
   assign tmo_hit     = (state == WAIT) && !bus.spi_rx_valid &&
                        (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign bus.rsp_err = rsp_err_q;
`else
   assign tmo_hit     = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (win_oh),
      .idx (win_idx)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (|bus.req_valid) state_nx = ARB;
         // Requests cannot be withdrawn, so the empty case is only a safety net.
         ARB:     state_nx = (|bus.req_valid) ? LAUNCH : IDLE;
         LAUNCH:  state_nx = WAIT;
         WAIT:    if (bus.spi_rx_valid || tmo_hit) state_nx = RESP;
         RESP:    state_nx = GAP;
         GAP:     if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      ready_c = '0;
      rsp_c   = '0;
      start_c = 1'b0;
      case (state)
         ARB:     ready_c = win_oh;
         LAUNCH:  start_c = 1'b1;
         RESP:    rsp_c   = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
         default: ;
      endcase
   end

   assign bus.req_ready    = ready_c;
   assign bus.rsp_valid    = rsp_c;
   assign bus.spi_tx_start = start_c;
   assign bus.spi_rx_start = start_c;
   assign bus.spi_tx_data  = tx_data_q;
   assign bus.spi_freq     = freq_q;
   assign bus.rsp_data     = rx_data_q;
   assign busy             = (state != IDLE);

   // Datapath: payload latch, capture, pointer and counters
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= '0;
         grant_id  <= '0;
         tx_data_q <= '0;
         freq_q    <= '0;
         rx_data_q <= '0;
         gap_cnt   <= '0;
         tx_seen   <= 1'b0;
`ifdef SPI_TIMEOUT_EN
         tmo_cnt   <= '0;
         rsp_err_q <= 1'b0;
`endif
      end else begin
         case (state)
            ARB: begin
               if (|bus.req_valid) begin
                  tx_data_q <= bus.req_data[int'(win_idx)*DW +: DW];
                  freq_q    <= bus.req_freq[int'(win_idx)*2 +: 2];
                  grant_id  <= win_idx;
               end
               tx_seen <= 1'b0;
            end
            LAUNCH: begin
`ifdef SPI_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT: begin
               // tx_done is informational; the frame ends on rx_valid only.
               tx_seen <= tx_seen | bus.spi_tx_done;
               if (bus.spi_rx_valid) begin
                  rx_data_q <= bus.spi_rx_data;
`ifdef SPI_TIMEOUT_EN
                  rsp_err_q <= 1'b0;
`endif
               end
`ifdef SPI_TIMEOUT_EN
               else if (tmo_hit) begin
                  rx_data_q <= '0;
                  rsp_err_q <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               ptr     <= IW'(next_ptr(int'(grant_id), NREQ));
               gap_cnt <= '0;
            end
            GAP:     gap_cnt <= gap_cnt + 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_txn_scheduler.sv
module tb_spi_txn_scheduler;
   import spi_sched_pkg::*;

   localparam int NREQ = 2;
   localparam int DW   = 16;
   localparam int GAPC = 4;
   localparam int TMO  = 64;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic busy;
   logic [$clog2(NREQ)-1:0] grant_id;

   spi_txn_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

   spi_txn_scheduler #(.NREQ(NREQ), .DW(DW), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TMO)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0, cyc = 0;

   // requester model
   bit           pend [NREQ];
   logic [DW-1:0] pdata [NREQ];
   logic [1:0]   pfreq [NREQ];
   int           fix_freq [NREQ];
   int           gen_pct = 0, stray_pct = 0;
   bit           drop_pending = 0, force_stray = 0, mute = 0;

   // scheduler reference: pointer, ownership, timing expectations
   int            ptr_m = 0, owner = 0, idle_from = 0, last_rsp = -1;
   int            rsp_cnt = 0, start_cnt = 0;
   bit            inflight = 0;
   logic [DW-1:0] own_data;
   logic [1:0]    own_freq;
   logic [NREQ-1:0] exp_ready_nx = '0, exp_rsp_nx = '0;
   bit            exp_start_nx = 0, exp_err = 0;
   logic [DW-1:0] exp_rsp_data = '0;

   // engine model
   bit            eng_act = 0;
   int            eng_cnt = 0;
   logic [DW-1:0] eng_resp;
   logic [DW-1:0] resp_q [$];
   int            grant_log [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   task automatic check_cycle();
      bit exp_busy;
      int g;
      exp_busy = (exp_ready_nx != 0) || inflight || (cyc < idle_from);
      chk("busy",      32'(busy), 32'(exp_busy));
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready_nx));
      chk("tx_start",  32'(bus.spi_tx_start), 32'(exp_start_nx));
      chk("rx_start",  32'(bus.spi_rx_start), 32'(exp_start_nx));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_nx));
      if (exp_ready_nx != 0) begin
         g = -1;
         for (int k = NREQ-1; k >= 0; k--) if (bus.req_ready[k]) g = k;
         grant_log.push_back(g);
         if (last_rsp >= 0) chk("gap", 32'(cyc - last_rsp > GAPC), 32'd1);
         inflight = 1;
      end
      if (exp_start_nx) begin
         chk("grant_id", 32'(grant_id), 32'(owner));
         start_cnt++;
         eng_act  = 1;
         eng_cnt  = mute ? TMO : 8 * (int'(own_freq) + 1) + int'($urandom_range(0, 3));
         eng_resp = (resp_q.size() > 0) ? resp_q.pop_front() : DW'($urandom);
      end
      if (eng_act) begin
         chk("spi_tx_data", 32'(bus.spi_tx_data), 32'(own_data));
         chk("spi_freq",    32'(bus.spi_freq), 32'(own_freq));
      end
      if (exp_rsp_nx != 0) begin
         chk("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp_data));
         chk("rsp_err",  32'(bus.rsp_err), 32'(exp_err));
         ptr_m     = (owner + 1) % NREQ;
         inflight  = 0;
         idle_from = cyc + GAPC + 1;
         last_rsp  = cyc;
         rsp_cnt++;
      end
   endtask

   task automatic drive_cycle();
      bit freeze;
      int w;
      freeze       = (exp_ready_nx != 0);
      exp_start_nx = freeze;
      exp_ready_nx = '0;
      exp_rsp_nx   = '0;
      bus.spi_rx_valid = 1'b0;
      bus.spi_tx_done  = 1'b0;
      if (eng_act) begin
         if (eng_cnt == 0) begin
            eng_act = 0;
            exp_rsp_nx[owner] = 1'b1;
            if (mute) begin
               exp_rsp_data = '0;
               exp_err      = 1;
            end else begin
               bus.spi_rx_valid = 1'b1;
               bus.spi_rx_data  = eng_resp;
               exp_rsp_data     = eng_resp;
               exp_err          = 0;
            end
         end else begin
            if (eng_cnt == 2) bus.spi_tx_done = 1'b1;
            eng_cnt--;
         end
      end else if (!inflight && !freeze &&
                   (force_stray || int'($urandom_range(0, 99)) < stray_pct)) begin
         bus.spi_rx_valid = 1'b1;
         bus.spi_rx_data  = DW'($urandom);
         bus.spi_tx_done  = 1'b1;
         force_stray      = 0;
      end
      if (freeze) begin
         drop_pending = 1;
         return;
      end
      if (drop_pending) begin
         pend[owner]  = 0;
         drop_pending = 0;
      end
      for (int k = 0; k < NREQ; k++)
         if (!pend[k] && int'($urandom_range(0, 99)) < gen_pct) begin
            pend[k]  = 1;
            pdata[k] = DW'($urandom);
            pfreq[k] = (fix_freq[k] >= 0) ? 2'(fix_freq[k]) : 2'($urandom);
         end
      for (int k = 0; k < NREQ; k++) begin
         bus.req_valid[k]           = pend[k];
         bus.req_data[k*DW +: DW]   = pdata[k];
         bus.req_freq[k*2 +: 2]     = pfreq[k];
      end
      if (!inflight && cyc >= idle_from) begin
         w = -1;
         for (int i = 0; i < NREQ; i++)
            if (w < 0 && pend[(ptr_m + i) % NREQ]) w = (ptr_m + i) % NREQ;
         if (w >= 0) begin
            exp_ready_nx[w] = 1'b1;
            owner    = w;
            own_data = pdata[w];
            own_freq = pfreq[w];
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      check_cycle();
      drive_cycle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      cyc++;
      reset = 1'b1;
      bus.spi_rx_valid = 1'b0;
      bus.spi_tx_done  = 1'b0;
      @(negedge clk);
      cyc++;
      chk("rst_busy",     32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_ready",    32'(bus.req_ready), 32'd0);
      chk("rst_rsp_vld",  32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_rsp_err",  32'(bus.rsp_err), 32'd0);
      chk("rst_tx_start", 32'(bus.spi_tx_start), 32'd0);
      chk("rst_rx_start", 32'(bus.spi_rx_start), 32'd0);
      chk("rst_tx_data",  32'(bus.spi_tx_data), 32'd0);
      chk("rst_freq",     32'(bus.spi_freq), 32'd0);
      reset        = 1'b0;
      ptr_m        = 0;
      inflight     = 0;
      eng_act      = 0;
      exp_ready_nx = '0;
      exp_rsp_nx   = '0;
      exp_start_nx = 0;
      drop_pending = 0;
      idle_from    = cyc;
      last_rsp     = -1;
      drive_cycle();
   endtask

   task automatic wait_rsp(input int target, input int budget, input string tag);
      int i = 0;
      while (rsp_cnt < target && i < budget) begin
         tick();
         i++;
      end
      chk(tag, 32'(rsp_cnt >= target), 32'd1);
   endtask

   task automatic drain(input int budget);
      int  i = 0;
      bit  any;
      any = 1;
      while (any && i < budget) begin
         tick();
         i++;
         any = inflight || (cyc < idle_from) || (exp_ready_nx != 0);
         for (int k = 0; k < NREQ; k++) any |= pend[k];
      end
      chk("drain", 32'(any), 32'd0);
   endtask

   initial begin
      int base;
      for (int k = 0; k < NREQ; k++) begin
         pend[k] = 0; pdata[k] = '0; pfreq[k] = '0; fix_freq[k] = -1;
      end
      bus.req_valid = '0; bus.req_data = '0; bus.req_freq = '0;
      bus.spi_rx_data = '0; bus.spi_rx_valid = 1'b0; bus.spi_tx_done = 1'b0;
      repeat (3) @(posedge clk);
      do_reset();

      // single request, fixed payload and slave response
      pend[0] = 1; pdata[0] = 16'hF1F1; pfreq[0] = 2'b11;
      resp_q.push_back(16'h000A);
      wait_rsp(1, 500, "t1_wait");
      chk("t1_rsp_data", 32'(bus.rsp_data), 32'h000A);

      // stray rx_valid/tx_done while idle, then a normal frame
      repeat (GAPC + 3) tick();
      force_stray = 1;
      repeat (4) tick();
      pend[0] = 1; pdata[0] = 16'h1234; pfreq[0] = 2'b01;
      wait_rsp(rsp_cnt + 1, 500, "t4_wait");

      // reset in WAIT while requester 1 owns the engine
      repeat (GAPC + 3) tick();
      pend[1] = 1; pdata[1] = 16'hBEEF; pfreq[1] = 2'b10;
      base = start_cnt;
      for (int i = 0; i < 200 && start_cnt == base; i++) tick();
      chk("t5_start", 32'(start_cnt > base), 32'd1);
      repeat (4) tick();
      base = rsp_cnt;
      do_reset();
      repeat (3) tick();
      chk("t5_no_rsp", 32'(rsp_cnt), 32'(base));

      // contention from pointer 0, fixed per-requester rates
      fix_freq[0] = 0; fix_freq[1] = 2;
      gen_pct = 100;
      base = grant_log.size();
      wait_rsp(rsp_cnt + 4, 2000, "t2_wait");
      gen_pct = 0;
      drain(2000);
      for (int i = 0; i < 4; i++)
         chk("rr_order", (grant_log.size() > base + i) ? 32'(grant_log[base + i]) : 32'hFFFF_FFFF,
             32'(i % 2));
      fix_freq[0] = -1; fix_freq[1] = -1;

`ifdef SPI_TIMEOUT_EN
      mute = 1;
      pend[0] = 1; pdata[0] = 16'h5A5A; pfreq[0] = 2'b00;
      wait_rsp(rsp_cnt + 1, 500, "t6_tmo_wait");
      mute = 0;
      pend[1] = 1; pdata[1] = 16'hA5A5; pfreq[1] = 2'b01;
      wait_rsp(rsp_cnt + 1, 500, "t6_next_wait");
`endif

      // randomized traffic with stray strobes
      gen_pct = 15; stray_pct = 5;
      wait_rsp(rsp_cnt + 30, 20000, "rand_wait");
      gen_pct = 0; stray_pct = 0;
      drain(2000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
